// File: rtl/cla_slice_sequencer.sv
// Purpose: WIDTH-bit adder built by time-multiplexing one external 4-bit CLA slice, LS nibble first.
// Latency: request accepted at edge k gives rsp_valid from edge k+NSLICE. One request per NSLICE+2 cycles at most.
// Backpressure: req_ready only in IDLE. The response holds in DONE until rsp_ready; no new accept in DONE.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   req_valid/req_ready      request handshake; req_a, req_b, req_cin are the operands
//   rsp_valid/rsp_ready      response handshake; rsp_sum, rsp_cout, rsp_ovf are the result
//   busy                     high while an operation is in RUN or DONE
//   slice_a/b/cin            nibble operands and carry driven to the shared CLA slice
//   slice_sum/cout           combinational result returned by the CLA slice
module cla_slice_sequencer #(
  parameter  int WIDTH  = 16,
  localparam int NSLICE = WIDTH / 4,
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_ovf,
  output logic             busy,
  output logic [3:0]       slice_a,
  output logic [3:0]       slice_b,
  output logic             slice_cin,
  input  logic [3:0]       slice_sum,
  input  logic             slice_cout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry;
  logic [IW-1:0]    idx;
  logic             last_nib;
  logic             accept;

  assign last_nib = (idx == IW'(NSLICE - 1));
  assign accept   = req_valid && req_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and outputs
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_sum   = '0;
    rsp_cout  = 1'b0;
    rsp_ovf   = 1'b0;
    busy      = 1'b0;
    slice_a   = 4'd0;
    slice_b   = 4'd0;
    slice_cin = 1'b0;
    case (state)
      IDLE: begin
        // Held low during reset so nothing upstream believes it was accepted.
        req_ready = !rst;
        if (req_valid && !rst) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy      = 1'b1;
        slice_a   = a_reg[4*idx +: 4];
        slice_b   = b_reg[4*idx +: 4];
        slice_cin = carry;
        if (last_nib) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
        rsp_sum   = sum_reg;
        rsp_cout  = carry;
        // Signed overflow: like-signed operands producing a result of the other sign.
        rsp_ovf   = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (sum_reg[WIDTH-1] != a_reg[WIDTH-1]);
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture and nibble-serial accumulation. The slice carry-out is
  // chained into the next pass purely through the carry register.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      sum_reg <= '0;
      carry   <= 1'b0;
      idx     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg <= req_a;
            b_reg <= req_b;
            carry <= req_cin;
            idx   <= '0;
          end
        end
        RUN: begin
          sum_reg[4*idx +: 4] <= slice_sum;
          carry               <= slice_cout;
          // Hold on the final nibble so idx never leaves 0..NSLICE-1.
          if (!last_nib) begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_slice_sequencer.sv
module tb_cla_slice_sequencer;

  localparam int WIDTH  = 16;
  localparam int NSLICE = WIDTH / 4;

  logic             clk;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             req_cin;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_sum;
  logic             rsp_cout;
  logic             rsp_ovf;
  logic             busy;
  logic [3:0]       slice_a;
  logic [3:0]       slice_b;
  logic             slice_cin;
  logic [3:0]       slice_sum;
  logic             slice_cout;

  int errors = 0;
  int checks = 0;

  cla_slice_sequencer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_cin    (req_cin),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .rsp_ovf    (rsp_ovf),
    .busy       (busy),
    .slice_a    (slice_a),
    .slice_b    (slice_b),
    .slice_cin  (slice_cin),
    .slice_sum  (slice_sum),
    .slice_cout (slice_cout)
  );

  // External 4-bit adder slice
  assign {slice_cout, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b} + {4'd0, slice_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              cin;
    logic [WIDTH-1:0]  sum;
    logic              cout;
    logic              ovf;
    logic [NSLICE-1:0] cseq;  // bit i = expected slice_cin in RUN cycle i
    int                hold;  // DONE cycles with rsp_ready low
    bit                noise; // keep req_valid high with changing operands
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("idle_req_ready", 32'(req_ready), 32'd1);
    req_a     = v.a;
    req_b     = v.b;
    req_cin   = v.cin;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    if (v.noise) begin
      req_a   = ~v.a;
      req_b   = v.a ^ 16'h5A5A;
      req_cin = ~v.cin;
    end else begin
      req_valid = 1'b0;
    end
    for (int i = 0; i < NSLICE; i++) begin
      @(negedge clk);
      chk("run_busy", 32'(busy), 32'd1);
      chk("run_req_ready", 32'(req_ready), 32'd0);
      chk("run_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("run_slice_a", 32'(slice_a), 32'(v.a[4*i +: 4]));
      chk("run_slice_b", 32'(slice_b), 32'(v.b[4*i +: 4]));
      chk("run_slice_cin", 32'(slice_cin), 32'(v.cseq[i]));
      if (v.noise) begin
        req_a = WIDTH'($urandom);
        req_b = WIDTH'($urandom);
      end
    end
    @(negedge clk);
    chk("done_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("done_sum", 32'(rsp_sum), 32'(v.sum));
    chk("done_cout", 32'(rsp_cout), 32'(v.cout));
    chk("done_ovf", 32'(rsp_ovf), 32'(v.ovf));
    chk("done_busy", 32'(busy), 32'd1);
    chk("done_slice_a", 32'(slice_a), 32'd0);
    for (int h = 0; h < v.hold; h++) begin
      req_valid = 1'b1;
      req_a     = 16'h0F0F;
      @(negedge clk);
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_sum", 32'(rsp_sum), 32'(v.sum));
      chk("hold_cout", 32'(rsp_cout), 32'(v.cout));
      chk("hold_ovf", 32'(rsp_ovf), 32'(v.ovf));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    // rsp_ready raised while req_valid may still be high: must not accept in DONE.
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_req_ready", 32'(req_ready), 32'd1);
    chk("post_sum_zero", 32'(rsp_sum), 32'd0);
  endtask

  initial begin
    vec_t v;
    //            a        b        cin   sum      cout  ovf   cseq     hold noise
    vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 4'b0110, 0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 4'b1111, 0, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 4'b1110, 0, 1'b0};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 4'b0000, 0, 1'b0};
    vecs[4] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 4'b0000, 3, 1'b0};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 4'b1111, 0, 1'b0};
    vecs[6] = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1, 4'b0000, 1, 1'b1};
    vecs[7] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 4'b1110, 0, 1'b1};

    rst       = 1'b1;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = 1'b0;
    rsp_ready = 1'b0;

    // Reset state, with a request pending that must not be acknowledged.
    repeat (2) @(negedge clk);
    req_valid = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_sum", 32'(rsp_sum), 32'd0);
    chk("rst_slice_cin", 32'(slice_cin), 32'd0);
    req_valid = 1'b0;
    rst       = 1'b0;
    @(negedge clk);
    chk("rst_release_ready", 32'(req_ready), 32'd1);
    chk("rst_release_busy", 32'(busy), 32'd0);

    for (int k = 0; k < 8; k++) begin
      run_vec(vecs[k]);
    end

    // Abort mid-RUN at idx=2, then a fresh request must complete normally.
    @(negedge clk);
    req_a     = 16'h5555;
    req_b     = 16'h1111;
    req_cin   = 1'b0;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("abort_slice_a_idx2", 32'(slice_a), 32'h5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_slice_a", 32'(slice_a), 32'd0);
    chk("abort_slice_b", 32'(slice_b), 32'd0);
    chk("abort_slice_cin", 32'(slice_cin), 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    // Several idle cycles: a stale response from the aborted request must not surface.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_stale", 32'(rsp_valid), 32'd0);
    end
    v = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0, 4'b0000, 0, 1'b0};
    run_vec(v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/cla_slice_sequencer.md
Name: cla_slice_sequencer

Overview:
Controller that performs WIDTH-bit additions by time-multiplexing one external 4-bit carry-lookahead adder slice. Each cycle it processes one nibble, least significant first, and chains the slice carry-out into the next nibble's carry-in. It accepts operands on a valid/ready request port and returns sum, carry-out and signed overflow on a valid/ready response port. It sits between the arithmetic issue logic and the shared four-bit CLA datapath.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4
NSLICE, WIDTH/4, number of nibble passes (derived; not overridden)

Ports:
clk  in  1  single clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request operands valid
req_ready  out  1  controller can accept a request
req_a  in  WIDTH  operand A
req_b  in  WIDTH  operand B
req_cin  in  1  carry-in to bit 0
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer accepts result
rsp_sum  out  WIDTH  A+B+cin, low WIDTH bits
rsp_cout  out  1  carry out of bit WIDTH-1
rsp_ovf  out  1  two's-complement overflow
busy  out  1  high in RUN or DONE
slice_a  out  4  nibble of A driven to CLA slice
slice_b  out  4  nibble of B driven to CLA slice
slice_cin  out  1  carry-in driven to CLA slice
slice_sum  in  4  CLA slice sum, combinational from slice_a/b/cin
slice_cout  in  1  CLA slice carry-out, combinational

Behaviour:
- Reset: state=IDLE, idx=0, carry=0, operand and sum registers=0; rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_ovf=0, busy=0, slice_a/b/cin=0. req_ready=0 while rst=1.
- Reset in any state, including mid-RUN, aborts the operation. No response is produced for the aborted request.
- IDLE: req_ready=1, busy=0, slice outputs=0.
  - On req_valid&req_ready: capture a, b and cin; idx<=0; carry<=req_cin; go to RUN.
- RUN: req_ready=0, busy=1. Slice outputs are driven combinationally from registers:
  - slice_a = a_reg[4*idx+3:4*idx]
  - slice_b = b_reg[4*idx+3:4*idx]
  - slice_cin = carry
  - Each edge: sum_reg[4*idx+3:4*idx] <= slice_sum; carry <= slice_cout; idx <= idx+1.
  - After the edge that processes idx=NSLICE-1, go to DONE.
- DONE: rsp_valid=1, req_ready=0, busy=1, slice outputs=0.
  - rsp_sum = sum_reg; rsp_cout = carry.
  - rsp_ovf = (a_reg[W-1]==b_reg[W-1]) && (sum_reg[W-1]!=a_reg[W-1]).
  - Outputs hold stable while rsp_ready=0.
  - On rsp_ready=1: go to IDLE; rsp_valid deasserts the next cycle.
- Latency: request accepted at edge k, rsp_valid=1 from edge k+NSLICE. WIDTH=16 gives 4 cycles.
- Throughput: at most one request per NSLICE+2 cycles. No accept in DONE, even when rsp_ready=1 in the same cycle.
- req_valid in RUN or DONE is ignored; operands change nothing until the next IDLE.
- Carry chaining is strictly through the carry register; the controller adds no carry logic of its own.
- idx width is clog2(NSLICE), minimum 1 bit. idx never wraps past NSLICE-1 in RUN.
- rsp outputs are 0 outside DONE.
- WIDTH=4 degenerates to a single RUN cycle.

Test Plan:
- WIDTH=16, a=0x00FF, b=0x0001, cin=0 -> after 4 cycles rsp_sum=0x0100, cout=0, ovf=0. slice_cin observed 0,1,1,0 across the four RUN cycles.
- a=0xFFFF, b=0x0000, cin=1 -> rsp_sum=0x0000, cout=1, ovf=0. slice_cin=1 in every RUN cycle (full-ripple chain).
- a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. Then a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
- Backpressure: rsp_ready=0 for 3 cycles in DONE -> rsp_valid, sum, cout and ovf stable; req_ready=0 despite req_valid=1. Raise rsp_ready -> IDLE next cycle; the following request (0x1234+0x4321) yields 0x5555.
- Reset asserted during RUN at idx=2 -> next cycle IDLE, rsp_valid=0, busy=0, slice outputs 0. New request 0xABCD+0x1111, cin=0 yields 0xBCDE; no stale response ever appears.
- req_valid held high with changing operands during RUN -> result reflects only the operands captured at acceptance.
